// File: rtl/execute_muldiv_unit_pkg.sv
// Shared types and op decoding for the execute-stage multiply/divide unit.
// No logic of its own; no latency.
// No backpressure of its own; handshakes live in the unit that imports it.
package execute_muldiv_unit_pkg;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

    typedef enum logic [1:0] {MD_S_IDLE, MD_S_MUL, MD_S_DIV, MD_S_DONE} muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/execute_muldiv_div_core.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
// Purely combinational, zero latency.
// No backpressure; the caller sequences the steps.
module execute_muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;

    // Extra top bit makes the borrow of the trial subtraction visible as diff's MSB.
    always_comb begin
        shifted = {rem_in, quot_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
        quot_out = {quot_in[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative signed/unsigned multiply (MUL_BITS per cycle) and restoring divide for Execute.
// Latency: MUL WIDTH/MUL_BITS+1, DIV WIDTH+1 (div-by-zero 1 when DIV_ZERO_FAST) cycles.
// in_ready only in IDLE; result held on out_valid until out_ready; flush aborts anywhere.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MUL_BITS      = 2,
    parameter int DIV_ZERO_FAST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             busy
);

    localparam int MUL_ITER = WIDTH / MUL_BITS;
    localparam int CW       = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    muldiv_state_t      state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;

    muldiv_op_t         op;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;

    assign op       = muldiv_op_t'(in_op);
    assign is_div   = op_is_div(op);
    assign sign_a   = op_is_signed(op) & in_a[WIDTH-1];
    assign sign_b   = op_is_signed(op) & in_b[WIDTH-1];
    assign a_mag    = cond_neg_w(sign_a, in_a);
    assign b_mag    = cond_neg_w(sign_b, in_b);
    assign div_zero = (in_b == '0);

    // Shift-add step: add multiplicand * low multiplier digit to the top half, shift right.
    logic [MUL_BITS-1:0]       mul_digit;
    logic [WIDTH+MUL_BITS-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_next;

    assign mul_digit = prod_q[MUL_BITS-1:0];
    assign mul_sum   = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]}
                     + ({{MUL_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mul_digit});
    assign mul_next  = {mul_sum, prod_q[WIDTH-1:MUL_BITS]};

    logic [WIDTH:0]   div_rem_next;
    logic [WIDTH-1:0] div_quot_next;

    execute_muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (divisor_q),
        .rem_out  (div_rem_next),
        .quot_out (div_quot_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_S_IDLE;
            count     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            raw_a_q   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_q      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_hi    <= '0;
            out_lo    <= '0;
        end else if (flush) begin
            state     <= MD_S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                MD_S_IDLE: begin
                    if (in_valid) begin
                        mcand_q   <= a_mag;
                        prod_q    <= {{WIDTH{1'b0}}, b_mag};
                        rem_q     <= '0;
                        quot_q    <= a_mag;
                        divisor_q <= b_mag;
                        raw_a_q   <= in_a;
                        neg_q     <= sign_a ^ sign_b;
                        neg_r     <= sign_a;
                        dz_q      <= is_div & div_zero;
                        if (!is_div)
                            count <= CW'(MUL_ITER);
                        else if (div_zero && DIV_ZERO_FAST != 0)
                            count <= '0;
                        else
                            count <= CW'(WIDTH);
                        state    <= is_div ? MD_S_DIV : MD_S_MUL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MD_S_MUL: begin
                    if (count == '0) begin
                        {out_hi, out_lo} <= cond_neg_2w(neg_q, prod_q);
                        out_valid        <= 1'b1;
                        state            <= MD_S_DONE;
                    end else begin
                        prod_q <= mul_next;
                        count  <= count - CW'(1);
                    end
                end
                MD_S_DIV: begin
                    if (count == '0) begin
                        if (dz_q) begin
                            out_lo <= '1;
                            out_hi <= raw_a_q;
                        end else begin
                            out_lo <= cond_neg_w(neg_q, quot_q);
                            out_hi <= cond_neg_w(neg_r, rem_q[WIDTH-1:0]);
                        end
                        out_valid <= 1'b1;
                        state     <= MD_S_DONE;
                    end else begin
                        rem_q  <= div_rem_next;
                        quot_q <= div_quot_next;
                        count  <= count - CW'(1);
                    end
                end
                MD_S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= MD_S_IDLE;
                    end
                end
                default: begin
                    state    <= MD_S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed-vector bench for execute_muldiv_unit with a queue scoreboard and an independent monitor.
module tb_execute_muldiv_unit;
    import execute_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_hi;
    logic [W-1:0] out_lo;
    logic         busy;

    execute_muldiv_unit #(.WIDTH(W), .MUL_BITS(2), .DIV_ZERO_FAST(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic seen = 1'b0;
    logic chk_idle = 1'b0;
    int   first_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_out_hi"}, 64'(out_hi), 64'd0);
        check({tag, "_out_lo"}, 64'(out_lo), 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) fail_timeout("issue_wait_in_ready");
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        if (push) begin
            e.hi  = hi;
            e.lo  = lo;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) fail_timeout("drain_scoreboard");
        tick();
        tick();
    endtask

    // Monitor: compares every delivered result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (chk_idle) begin
                check("idle_after_handshake_in_ready", 64'(in_ready), 64'd1);
                check("idle_after_handshake_busy", 64'(busy), 64'd0);
                chk_idle = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got hi=0x%0h lo=0x%0h required no result", out_hi, out_lo);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        first_cyc = cyc;
                    end
                    if (!out_ready) begin
                        check("held_out_hi", 64'(out_hi), 64'(sb[0].hi));
                        check("held_out_lo", 64'(out_lo), 64'(sb[0].lo));
                        check("held_in_ready", 64'(in_ready), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_hi", 64'(out_hi), 64'(e.hi));
                        check("out_lo", 64'(out_lo), 64'(e.lo));
                        check("latency", 64'(first_cyc - e.acc - 1), 64'(e.lat));
                        seen = 1'b0;
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state("reset");

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 17);
        issue(MD_MULT,  32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 17);
        issue(MD_MULT,  32'hFFFFFFFD, 32'h00000005, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 17);
        issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        issue(MD_DIVU,  32'h00000007, 32'h00000002, 1, 32'h00000001, 32'h00000003, 33);
        issue(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 33);
        issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 33);
        issue(MD_DIVU,  32'h00001234, 32'h00000000, 1, 32'h00001234, 32'hFFFFFFFF, 1);
        issue(MD_DIV,   32'hFFFFFFFB, 32'h00000000, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
        drain();

        // Flush in the middle of a divide: the op must vanish without a result.
        issue(MD_DIV, 32'd100, 32'd3, 0, '0, '0, 0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (40) tick();
        issue(MD_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, 17);
        drain();

        // Consumer stalls for 10 cycles: result must be held steady.
        out_ready = 1'b0;
        issue(MD_MULTU, 32'h12345678, 32'h00000010, 1, 32'h00000001, 32'h23456780, 17);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) fail_timeout("stall_wait_out_valid");
        repeat (10) tick();
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a multiply discards it and clears the outputs.
        issue(MD_MULT, 32'd5, 32'd7, 0, '0, '0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("midop_reset");
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
